if_id_queue: RTL

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue_pkg.sv | 33 +++
 rtl/if_id_queue_mem.sv | 50 +++++
 rtl/if_id_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue.
// Bus widths, the reset fetch address, the default queue depth, the
// {pc, npc, inst} entry layout and small decode helpers.
package if_id_queue_pkg;

  localparam int          PC_BUS      = 32;
  localparam int          INST_BUS    = 32;
  localparam logic [31:0] NPC_INITIAL = 32'h0000_0000;
  localparam int          QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [PC_BUS-1:0]   pc;
    logic [PC_BUS-1:0]   npc;
    logic [INST_BUS-1:0] inst;
  } entry_t;

  // Entries requested by decode; the illegal code 01 requests nothing.
  function automatic logic [1:0] take_count(input logic [1:0] id_take);
    logic [1:0] n;
    case (id_take)
      2'b10:   n = 2'd1;
      2'b11:   n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Entries offered by fetch: one per set bit of the issue mask.
  function automatic logic [1:0] issue_count(input logic [1:0] issue);
    return {1'b0, issue[1]} + {1'b0, issue[0]};
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Storage array for the IF/ID queue: DEPTH entries of {pc, npc, inst}.
// Ports:
//   clk, rst            - clock, asynchronous active-high clear of all entries
//   we1/waddr1/wdata1   - write port 1
//   we2/waddr2/wdata2   - write port 2 (never the same address as port 1)
//   raddr1/rdata1       - read port 1 (combinational read)
//   raddr2/rdata2       - read port 2 (combinational read)
// No pointer or occupancy logic lives here.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter  int DEPTH = QUEUE_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  entry_t        wdata1,
  input  logic          we2,
  input  logic [AW-1:0] waddr2,
  input  entry_t        wdata2,
  input  logic [AW-1:0] raddr1,
  output entry_t        rdata1,
  input  logic [AW-1:0] raddr2,
  output entry_t        rdata2
);

  entry_t mem_r [DEPTH];

  // Entry storage: cleared on reset, written by either port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(entry_t){1'b0}};
      end
    end else begin
      if (we1) begin
        mem_r[waddr1] <= wdata1;
      end
      if (we2) begin
        mem_r[waddr2] <= wdata2;
      end
    end
  end

  assign rdata1 = mem_r[raddr1];
  assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a circular FIFO between fetch and decode.
// Fetch offers up to two instructions per cycle (issue mask), decode takes
// up to two (id_take). stop tells fetch to hold whenever fewer than two free
// entries remain, so an accepted push can never overflow.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   in1_*/in2_*, issue        - fetch slots (slot 1 older) and their valid mask
//   branch_flag               - mispredict: flush everything this edge
//   stop                      - fetch hold, decoded from registered occupancy
//   out1_*/out2_*, out_valid  - entries at head and head+1 with valid mask
//   id_take                   - decode consumption (00 none, 10 one, 11 two)
//   count                     - current occupancy
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter  int DEPTH = QUEUE_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_BUS-1:0]   in1_pc,
  input  logic [PC_BUS-1:0]   in1_npc,
  input  logic [INST_BUS-1:0] in1_inst,
  input  logic [PC_BUS-1:0]   in2_pc,
  input  logic [PC_BUS-1:0]   in2_npc,
  input  logic [INST_BUS-1:0] in2_inst,
  input  logic [1:0]          issue,
  input  logic                branch_flag,
  output logic                stop,
  output logic [PC_BUS-1:0]   out1_pc,
  output logic [PC_BUS-1:0]   out1_npc,
  output logic [INST_BUS-1:0] out1_inst,
  output logic [PC_BUS-1:0]   out2_pc,
  output logic [PC_BUS-1:0]   out2_npc,
  output logic [INST_BUS-1:0] out2_inst,
  output logic [1:0]          out_valid,
  input  logic [1:0]          id_take,
  output logic [CW-1:0]       count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          stop_r;

  logic          push_ok_s;
  logic [1:0]    push_n_s;
  logic [1:0]    pop_req_s;
  logic [1:0]    pop_n_s;
  logic          we1_s;
  logic          we2_s;
  entry_t        wdata1_s;
  entry_t        wdata2_s;
  logic [AW-1:0] waddr2_s;
  logic [AW-1:0] head_next_s;
  logic [AW-1:0] tail_next_s;
  logic [CW-1:0] count_next_s;
  logic          stop_next_s;
  entry_t        rdata1_s;
  entry_t        rdata2_s;

  // Push/pop decode and next-state computation for pointers and occupancy.
  always_comb begin
    push_ok_s = !stop_r && !branch_flag;
    pop_req_s = take_count(id_take);
    // Clamp the pop to what is actually held; count < 2 fits in two bits.
    if (CW'(pop_req_s) > count_r) begin
      pop_n_s = count_r[1:0];
    end else begin
      pop_n_s = pop_req_s;
    end
    if (push_ok_s) begin
      push_n_s = issue_count(issue);
    end else begin
      push_n_s = 2'd0;
    end

    // A lone slot-2 push still lands at tail, so port 1 carries whichever
    // slot is the oldest one being pushed.
    we1_s    = push_ok_s && (issue != 2'b00);
    we2_s    = push_ok_s && (issue == 2'b11);
    wdata2_s = '{pc: in2_pc, npc: in2_npc, inst: in2_inst};
    if (issue[1]) begin
      wdata1_s = '{pc: in1_pc, npc: in1_npc, inst: in1_inst};
    end else begin
      wdata1_s = wdata2_s;
    end
    waddr2_s = tail_r + AW'(1);

    if (branch_flag) begin
      head_next_s  = {AW{1'b0}};
      tail_next_s  = {AW{1'b0}};
      count_next_s = {CW{1'b0}};
    end else begin
      head_next_s  = head_r + AW'(pop_n_s);
      tail_next_s  = tail_r + AW'(push_n_s);
      count_next_s = count_r + CW'(push_n_s) - CW'(pop_n_s);
    end
    stop_next_s = (DEPTH_C - count_next_s) < CW'(2);
  end

  // Pointer, occupancy and fetch-hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      stop_r  <= 1'b0;
    end else begin
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      count_r <= count_next_s;
      stop_r  <= stop_next_s;
    end
  end

  if_id_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we1    (we1_s),
    .waddr1 (tail_r),
    .wdata1 (wdata1_s),
    .we2    (we2_s),
    .waddr2 (waddr2_s),
    .wdata2 (wdata2_s),
    .raddr1 (head_r),
    .rdata1 (rdata1_s),
    .raddr2 (head_r + AW'(1)),
    .rdata2 (rdata2_s)
  );

  assign stop      = stop_r;
  assign count     = count_r;
  // A flush in progress hides both entries immediately.
  assign out_valid = branch_flag ? 2'b00 : {count_r >= CW'(1), count_r >= CW'(2)};
  assign out1_pc   = rdata1_s.pc;
  assign out1_npc  = rdata1_s.npc;
  assign out1_inst = rdata1_s.inst;
  assign out2_pc   = rdata2_s.pc;
  assign out2_npc  = rdata2_s.npc;
  assign out2_inst = rdata2_s.inst;

endmodule
